stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, count/display word width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a button level (legal range ≥2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_btn_start  input  1  raw start/stop button, active-high, asynchronous to clk, may bounce.
REQ-006 i_btn_lap  input  1  raw lap/clear button, active-high, asynchronous, may bounce.
REQ-007 i_tick  input  1  one-cycle enable pulse from the clock divider.
REQ-008 i_cnt  input  WIDTH  live count from the timer.
REQ-009 o_timer_en  output  1  gated enable to the timer.
REQ-010 o_timer_clr  output  1  one-cycle synchronous clear pulse to the timer.
REQ-011 o_val  output  WIDTH  value to the hex display.
REQ-012 o_running  output  1  high in RUN or LAP.
REQ-013 o_frozen  output  1  high in LAP.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, reset to 0 on any cycle they match, and on reaching DEBOUNCE_CYCLES-1 while still differing SHALL update the debounced level and reset to 0 on the next edge.
REQ-016 A press SHALL be a one-cycle pulse on the debounced rising edge; falling edges generate nothing.
REQ-017 Total latency: raw level change first sampled at edge E0 SHALL change FSM state at edge E0+DEBOUNCE_CYCLES+3, exactly.
REQ-018 Bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no press.
REQ-019 FSM states: IDLE, RUN, LAP, STOP.
REQ-020 IDLE: start press -> RUN; lap press -> stay IDLE and issue o_timer_clr.
REQ-021 RUN: start press -> STOP; lap press -> LAP and capture i_cnt into the hold register on that same edge.
REQ-022 LAP: lap press -> RUN (release freeze); start press -> STOP.
REQ-023 STOP: start press -> RUN (resume, no clear); lap press -> IDLE and issue o_timer_clr.
REQ-024 Start and lap presses on the same cycle: start SHALL win, lap SHALL be discarded.
REQ-025 o_timer_clr SHALL be registered, high exactly one cycle, asserted the cycle after the qualifying press.
REQ-026 o_timer_en SHALL be combinational: i_tick AND (state is RUN or LAP); no ticks lost or duplicated.
REQ-027 o_val SHALL equal the hold register in LAP, else i_cnt (combinational pass-through).
REQ-028 Hold register SHALL be WIDTH bits, written only on RUN->LAP, never cleared except by rst.
REQ-029 o_running and o_frozen SHALL be decoded from the state register (no extra latency).

Reset
REQ-030 While rst is high at a clock edge: state IDLE, synchronizers, debounced levels, debounce counters, hold register all 0, o_timer_clr 0.
REQ-031 Resulting outputs: o_timer_en 0, o_running 0, o_frozen 0, o_val = i_cnt.
REQ-032 Reset mid-operation SHALL return to IDLE on the next edge and SHALL NOT pulse o_timer_clr.
REQ-033 A button held high across reset release SHALL be treated as a new press after the REQ-017 latency.

Verification (DEBOUNCE_CYCLES=4, WIDTH=16)
REQ-034 Clean start press held 20 cycles from IDLE -> RUN entered exactly 7 edges after first sample; o_running 1; o_timer_en mirrors i_tick.
REQ-035 Start input toggling every 2 cycles for 40 cycles -> no state change, o_timer_clr never asserted.
REQ-036 RUN with i_cnt=0x0123, lap press -> LAP, o_frozen 1, o_val holds 0x0123 while i_cnt advances to 0x0130; second lap -> RUN, o_val=i_cnt.
REQ-037 RUN -> start -> STOP (o_timer_en 0 under ticks) -> lap -> IDLE with o_timer_clr high exactly 1 cycle.
REQ-038 Start and lap raw edges applied on the same cycle in RUN -> STOP, hold register unchanged, no clear.
REQ-039 rst asserted for 1 cycle in LAP -> IDLE, o_val=i_cnt, hold register 0, no o_timer_clr pulse.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - timer-side bundle between stopwatch controller and timer
interface stopwatch_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             i_tick;
    logic [WIDTH-1:0] i_cnt;
    logic             o_timer_en;
    logic             o_timer_clr;

    modport master (
        input  i_tick,
        input  i_cnt,
        output o_timer_en,
        output o_timer_clr
    );

    modport slave (
        output i_tick,
        output i_cnt,
        input  o_timer_en,
        input  o_timer_clr
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - debounced two-button stopwatch controller with lap freeze
module stopwatch_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_btn_start,
    input  logic               i_btn_lap,
    stopwatch_ctrl_if.master   tmr,
    output logic [WIDTH-1:0]   o_val,
    output logic               o_running,
    output logic               o_frozen
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    // bit 0 = start button, bit 1 = lap button
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_prev;
    logic [1:0]    r_press;
    logic [CW-1:0] r_dcnt [2];

    state_t           r_state;
    state_t           w_state_next;
    logic             r_clr;
    logic             w_clr_next;
    logic             w_hold_we;
    logic [WIDTH-1:0] r_hold;
    logic             w_start;
    logic             w_lap;

    assign w_raw = {i_btn_lap, i_btn_start};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_deb_prev <= '0;
            r_press    <= '0;
            for (int i = 0; i < 2; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            // registered edge detect adds the final cycle of press latency
            r_press    <= r_deb & ~r_deb_prev;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_dcnt[i] == DB_LAST) begin
                        r_deb[i]  <= r_sync2[i];
                        r_dcnt[i] <= '0;
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + 1'b1;
                    end
                end else begin
                    r_dcnt[i] <= '0;
                end
            end
        end
    end

    // start wins a tie, so lap only counts when start is absent
    assign w_start = r_press[0];
    assign w_lap   = r_press[1] & ~r_press[0];

    always_comb begin
        w_state_next = r_state;
        w_clr_next   = 1'b0;
        w_hold_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = RUN;
                end else if (w_lap) begin
                    w_clr_next = 1'b1;
                end
            end
            RUN: begin
                if (w_start) begin
                    w_state_next = STOP;
                end else if (w_lap) begin
                    w_state_next = LAP;
                    w_hold_we    = 1'b1;
                end
            end
            LAP: begin
                if (w_start) begin
                    w_state_next = STOP;
                end else if (w_lap) begin
                    w_state_next = RUN;
                end
            end
            STOP: begin
                if (w_start) begin
                    w_state_next = RUN;
                end else if (w_lap) begin
                    w_state_next = IDLE;
                    w_clr_next   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_clr   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_clr   <= w_clr_next;
            if (w_hold_we) begin
                r_hold <= tmr.i_cnt;
            end
        end
    end

    assign o_running       = (r_state == RUN) || (r_state == LAP);
    assign o_frozen        = (r_state == LAP);
    assign tmr.o_timer_en  = tmr.i_tick & o_running;
    assign tmr.o_timer_clr = r_clr;
    assign o_val           = o_frozen ? r_hold : tmr.i_cnt;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed table-driven bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
    localparam int WIDTH = 16;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_start;
    logic             btn_lap;
    logic [WIDTH-1:0] o_val;
    logic             o_running;
    logic             o_frozen;

    stopwatch_ctrl_if #(.WIDTH(WIDTH)) tmr ();

    stopwatch_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_start (btn_start),
        .i_btn_lap   (btn_lap),
        .tmr         (tmr),
        .o_val       (o_val),
        .o_running   (o_running),
        .o_frozen    (o_frozen)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int clr_seen = 0;

    always @(negedge clk) begin
        if (tmr.o_timer_clr === 1'b1) clr_seen++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        rst       = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic press(input logic s, input logic l);
        btn_start = s;
        btn_lap   = l;
        step(3 * DEB);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        step(3 * DEB);
    endtask

    typedef struct {
        logic             start;
        logic             lap;
        logic [WIDTH-1:0] cnt_press;
        logic [WIDTH-1:0] cnt_after;
        logic             exp_run;
        logic             exp_frz;
        int               exp_clr;
        logic [WIDTH-1:0] exp_val;
        logic [WIDTH-1:0] exp_hold;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0011, 1'b1, 1'b0, 0, 16'h0011, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0123, 16'h0130, 1'b1, 1'b1, 0, 16'h0123, 16'h0123};
        vecs[2] = '{1'b0, 1'b1, 16'h0140, 16'h0141, 1'b1, 1'b0, 0, 16'h0141, 16'h0123};
        vecs[3] = '{1'b1, 1'b0, 16'h0145, 16'h0150, 1'b0, 1'b0, 0, 16'h0150, 16'h0123};
        vecs[4] = '{1'b0, 1'b1, 16'h0150, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 16'h0123};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 16'h0123};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1, 1'b0, 0, 16'h0005, 16'h0123};
        vecs[7] = '{1'b1, 1'b1, 16'h0200, 16'h0201, 1'b0, 1'b0, 0, 16'h0201, 16'h0123};
        vecs[8] = '{1'b1, 1'b0, 16'h0201, 16'h0202, 1'b1, 1'b0, 0, 16'h0202, 16'h0123};
        vecs[9] = '{1'b0, 1'b1, 16'h0300, 16'h0310, 1'b1, 1'b1, 0, 16'h0300, 16'h0300};

        tmr.i_tick = 1'b0;
        tmr.i_cnt  = 16'h0042;
        do_reset();

        check("reset_running", o_running, 1'b0);
        check("reset_frozen", o_frozen, 1'b0);
        check("reset_val", o_val, 16'h0042);
        check("reset_clr", tmr.o_timer_clr, 1'b0);
        tmr.i_tick = 1'b1;
        #1;
        check("reset_en", tmr.o_timer_en, 1'b0);
        tmr.i_tick = 1'b0;

        // exact latency: first sample at E0, RUN entered at E0+7
        btn_start = 1'b1;
        step(DEB + 3);
        check("latency_before", o_running, 1'b0);
        step(1);
        check("latency_at", o_running, 1'b1);
        tmr.i_tick = 1'b1;
        #1;
        check("en_tick_hi", tmr.o_timer_en, 1'b1);
        tmr.i_tick = 1'b0;
        #1;
        check("en_tick_lo", tmr.o_timer_en, 1'b0);
        step(20 - (DEB + 4));
        btn_start = 1'b0;
        step(3 * DEB);

        // bounce shorter than the debounce window: no press, no clear
        clr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            btn_start = ~btn_start;
            step(2);
        end
        step(3 * DEB);
        check("bounce_running", o_running, 1'b1);
        check("bounce_frozen", o_frozen, 1'b0);
        check("bounce_clr", clr_seen, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            tmr.i_cnt = vecs[i].cnt_press;
            clr_seen  = 0;
            press(vecs[i].start, vecs[i].lap);
            tmr.i_cnt  = vecs[i].cnt_after;
            tmr.i_tick = 1'b1;
            #1;
            check($sformatf("v%0d_running", i), o_running, vecs[i].exp_run);
            check($sformatf("v%0d_frozen", i), o_frozen, vecs[i].exp_frz);
            check($sformatf("v%0d_en", i), tmr.o_timer_en, vecs[i].exp_run);
            check($sformatf("v%0d_val", i), o_val, vecs[i].exp_val);
            check($sformatf("v%0d_hold", i), dut.r_hold, vecs[i].exp_hold);
            check($sformatf("v%0d_clr", i), clr_seen, vecs[i].exp_clr);
            tmr.i_tick = 1'b0;
        end

        // one-cycle reset while in LAP
        clr_seen  = 0;
        tmr.i_cnt = 16'h0777;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("rst_lap_frozen", o_frozen, 1'b0);
        check("rst_lap_running", o_running, 1'b0);
        check("rst_lap_val", o_val, 16'h0777);
        check("rst_lap_hold", dut.r_hold, 16'h0000);
        step(4);
        check("rst_lap_clr", clr_seen, 0);

        // button held across reset release becomes a fresh press
        btn_start = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(DEB + 3);
        check("held_rst_before", o_running, 1'b0);
        step(1);
        check("held_rst_at", o_running, 1'b1);
        btn_start = 1'b0;
        step(3 * DEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
